// File: rtl/axi_slice_pkg.sv
// Shared types for the AXI register slice.
//   slice_mode_e : per-channel slice mode (BYPASS / LIGHT / FULL)
//   *_pl_w()     : packed payload width of each AXI channel
package axi_slice_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    LIGHT  = 2'd1,
    FULL   = 2'd2
  } slice_mode_e;

  // AW and AR: ID, ADDR, LEN, SIZE, BURST, LOCK, CACHE, PROT
  function automatic int ax_pl_w(int id_w, int addr_w, int len_w, int size_w,
                                 int burst_w, int lock_w, int cache_w, int prot_w);
    return id_w + addr_w + len_w + size_w + burst_w + lock_w + cache_w + prot_w;
  endfunction

  // W: ID, DATA, STRB, LAST
  function automatic int w_pl_w(int id_w, int data_w);
    return id_w + data_w + data_w / 8 + 1;
  endfunction

  // B: ID, RESP
  function automatic int b_pl_w(int id_w, int resp_w);
    return id_w + resp_w;
  endfunction

  // R: ID, DATA, RESP, LAST
  function automatic int r_pl_w(int id_w, int data_w, int resp_w);
    return id_w + data_w + resp_w + 1;
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI3-style bundle (with WID) used on both sides of the register slice.
//   initiator : drives AW/W/AR and BREADY/RREADY
//   target    : drives AWREADY/WREADY/ARREADY and B/R
interface axi_if #(
  parameter int AXI_ID_W    = 8,
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_DATA_W  = 32,
  parameter int AXI_LEN_W   = 4,
  parameter int AXI_SIZE_W  = 3,
  parameter int AXI_BURST_W = 2,
  parameter int AXI_LOCK_W  = 2,
  parameter int AXI_CACHE_W = 4,
  parameter int AXI_PROT_W  = 3,
  parameter int AXI_RESP_W  = 2
);
  localparam int AXI_STB_W = AXI_DATA_W / 8;

  logic [AXI_ID_W-1:0]    AWID,    ARID,    WID,  BID,  RID;
  logic [AXI_ADDR_W-1:0]  AWADDR,  ARADDR;
  logic [AXI_LEN_W-1:0]   AWLEN,   ARLEN;
  logic [AXI_SIZE_W-1:0]  AWSIZE,  ARSIZE;
  logic [AXI_BURST_W-1:0] AWBURST, ARBURST;
  logic [AXI_LOCK_W-1:0]  AWLOCK,  ARLOCK;
  logic [AXI_CACHE_W-1:0] AWCACHE, ARCACHE;
  logic [AXI_PROT_W-1:0]  AWPROT,  ARPROT;
  logic [AXI_DATA_W-1:0]  WDATA,   RDATA;
  logic [AXI_STB_W-1:0]   WSTRB;
  logic [AXI_RESP_W-1:0]  BRESP,   RRESP;
  logic                   WLAST,   RLAST;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY;

  modport initiator (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport target (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi_slice_ch.sv
// Generic single-channel valid/ready slice.
//   gclk, grst_n     : clock, async active-low reset
//   s_valid/s_ready  : upstream handshake, s_data payload in
//   m_valid/m_ready  : downstream handshake, m_data payload out
// MODE: BYPASS = wires, LIGHT = 1 register (half rate),
//       FULL = 2-entry skid buffer (full rate, registered ready).
module axi_slice_ch
  import axi_slice_pkg::*;
#(
  parameter int          W    = 8,
  parameter slice_mode_e MODE = FULL
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  if (MODE == BYPASS) begin : g_byp
    logic unused;
    assign unused  = gclk ^ grst_n;
    assign m_valid = s_valid;
    assign s_ready = m_ready;
    assign m_data  = s_data;

  end else if (MODE == LIGHT) begin : g_light
    logic         full_q, rdy_q, push, full_n;
    logic [W-1:0] data_q;

    // rdy_q tracks !full but sits at 0 through reset and the release edge
    assign push   = s_valid & rdy_q;
    assign full_n = push | (full_q & ~m_ready);

    always_ff @(posedge gclk or negedge grst_n)
      if (!grst_n) begin
        full_q <= 1'b0;
        rdy_q  <= 1'b0;
      end else begin
        full_q <= full_n;
        rdy_q  <= ~full_n;
      end

    always_ff @(posedge gclk)
      if (push) data_q <= s_data;

    assign s_ready = rdy_q;
    assign m_valid = full_q;
    assign m_data  = data_q;

  end else begin : g_full
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]   st_q, st_n;
    logic         rdy_q, push, pop;
    logic [W-1:0] out_q, skid_q;

    assign push = s_valid & rdy_q;
    assign pop  = (st_q != ST_EMPTY) & m_ready;

    always_comb begin
      st_n = st_q;
      case (st_q)
        ST_EMPTY: if (push) st_n = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      st_n = ST_TWO;
          else if (!push && pop) st_n = ST_EMPTY;
        end
        ST_TWO:   if (pop) st_n = ST_ONE;
        default:  st_n = ST_EMPTY;
      endcase
    end

    // ready is registered from the next state, so it never sees m_ready combinationally
    always_ff @(posedge gclk or negedge grst_n)
      if (!grst_n) begin
        st_q  <= ST_EMPTY;
        rdy_q <= 1'b0;
      end else begin
        st_q  <= st_n;
        rdy_q <= (st_n != ST_TWO);
      end

    // out_q is the head beat; skid_q catches the beat that arrives while head stalls
    always_ff @(posedge gclk) begin
      if ((st_q == ST_EMPTY && push) || (st_q == ST_ONE && push && pop))
        out_q <= s_data;
      else if (st_q == ST_TWO && pop)
        out_q <= skid_q;
      if (st_q == ST_ONE && push && !pop)
        skid_q <= s_data;
    end

    assign s_ready = rdy_q;
    assign m_valid = (st_q != ST_EMPTY);
    assign m_data  = out_q;
  end

endmodule

// File: rtl/axi_reg_slice.sv
// AXI register slice: five independent channel slices between s_axi and m_axi.
//   ACLK, ARESETn : clock, async active-low reset
//   s_axi         : upstream (initiator-facing) side
//   m_axi         : downstream (target-facing) side
// AW/W/AR flow s_axi -> m_axi, B/R flow m_axi -> s_axi. No storage here.
module axi_reg_slice
  import axi_slice_pkg::*;
#(
  parameter int          AXI_ID_W    = 8,
  parameter int          AXI_ADDR_W  = 32,
  parameter int          AXI_DATA_W  = 32,
  parameter int          AXI_LEN_W   = 4,
  parameter int          AXI_SIZE_W  = 3,
  parameter int          AXI_BURST_W = 2,
  parameter int          AXI_LOCK_W  = 2,
  parameter int          AXI_CACHE_W = 4,
  parameter int          AXI_PROT_W  = 3,
  parameter int          AXI_RESP_W  = 2,
  parameter slice_mode_e AW_MODE     = FULL,
  parameter slice_mode_e W_MODE      = FULL,
  parameter slice_mode_e B_MODE      = FULL,
  parameter slice_mode_e AR_MODE     = FULL,
  parameter slice_mode_e R_MODE      = FULL
) (
  input  logic      ACLK,
  input  logic      ARESETn,
  axi_if.target     s_axi,
  axi_if.initiator  m_axi
);

  localparam int AX_W = ax_pl_w(AXI_ID_W, AXI_ADDR_W, AXI_LEN_W, AXI_SIZE_W,
                                AXI_BURST_W, AXI_LOCK_W, AXI_CACHE_W, AXI_PROT_W);
  localparam int WW   = w_pl_w(AXI_ID_W, AXI_DATA_W);
  localparam int BW   = b_pl_w(AXI_ID_W, AXI_RESP_W);
  localparam int RW   = r_pl_w(AXI_ID_W, AXI_DATA_W, AXI_RESP_W);

  logic [AX_W-1:0] aw_s, aw_m, ar_s, ar_m;
  logic [WW-1:0]   w_s, w_m;
  logic [BW-1:0]   b_s, b_m;
  logic [RW-1:0]   r_s, r_m;

  // _s = slice input, _m = slice output
  assign aw_s = {s_axi.AWID, s_axi.AWADDR, s_axi.AWLEN, s_axi.AWSIZE,
                 s_axi.AWBURST, s_axi.AWLOCK, s_axi.AWCACHE, s_axi.AWPROT};
  assign {m_axi.AWID, m_axi.AWADDR, m_axi.AWLEN, m_axi.AWSIZE,
          m_axi.AWBURST, m_axi.AWLOCK, m_axi.AWCACHE, m_axi.AWPROT} = aw_m;

  assign w_s = {s_axi.WID, s_axi.WDATA, s_axi.WSTRB, s_axi.WLAST};
  assign {m_axi.WID, m_axi.WDATA, m_axi.WSTRB, m_axi.WLAST} = w_m;

  assign ar_s = {s_axi.ARID, s_axi.ARADDR, s_axi.ARLEN, s_axi.ARSIZE,
                 s_axi.ARBURST, s_axi.ARLOCK, s_axi.ARCACHE, s_axi.ARPROT};
  assign {m_axi.ARID, m_axi.ARADDR, m_axi.ARLEN, m_axi.ARSIZE,
          m_axi.ARBURST, m_axi.ARLOCK, m_axi.ARCACHE, m_axi.ARPROT} = ar_m;

  assign b_s = {m_axi.BID, m_axi.BRESP};
  assign {s_axi.BID, s_axi.BRESP} = b_m;

  assign r_s = {m_axi.RID, m_axi.RDATA, m_axi.RRESP, m_axi.RLAST};
  assign {s_axi.RID, s_axi.RDATA, s_axi.RRESP, s_axi.RLAST} = r_m;

  axi_slice_ch #(.W(AX_W), .MODE(AW_MODE)) u_aw (
    .gclk(ACLK), .grst_n(ARESETn),
    .s_valid(s_axi.AWVALID), .s_ready(s_axi.AWREADY), .s_data(aw_s),
    .m_valid(m_axi.AWVALID), .m_ready(m_axi.AWREADY), .m_data(aw_m));

  axi_slice_ch #(.W(WW), .MODE(W_MODE)) u_w (
    .gclk(ACLK), .grst_n(ARESETn),
    .s_valid(s_axi.WVALID), .s_ready(s_axi.WREADY), .s_data(w_s),
    .m_valid(m_axi.WVALID), .m_ready(m_axi.WREADY), .m_data(w_m));

  axi_slice_ch #(.W(AX_W), .MODE(AR_MODE)) u_ar (
    .gclk(ACLK), .grst_n(ARESETn),
    .s_valid(s_axi.ARVALID), .s_ready(s_axi.ARREADY), .s_data(ar_s),
    .m_valid(m_axi.ARVALID), .m_ready(m_axi.ARREADY), .m_data(ar_m));

  axi_slice_ch #(.W(BW), .MODE(B_MODE)) u_b (
    .gclk(ACLK), .grst_n(ARESETn),
    .s_valid(m_axi.BVALID), .s_ready(m_axi.BREADY), .s_data(b_s),
    .m_valid(s_axi.BVALID), .m_ready(s_axi.BREADY), .m_data(b_m));

  axi_slice_ch #(.W(RW), .MODE(R_MODE)) u_r (
    .gclk(ACLK), .grst_n(ARESETn),
    .s_valid(m_axi.RVALID), .s_ready(m_axi.RREADY), .s_data(r_s),
    .m_valid(s_axi.RVALID), .m_ready(s_axi.RREADY), .m_data(r_m));

endmodule
